// File: rtl/xor_sched.sv
`default_nettype none
// ============================================================================
//  Module   : xor_sched
//  Purpose  : Round-robin scheduler sharing one registered XOR datapath
//             (Y = A ^ B) among NREQ requesters. One requester is granted in
//             IDLE, the XOR is computed in a dedicated EXEC cycle, and the
//             result is held on the shared response channel in RESP until the
//             consumer takes it.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready    - per-requester handshake (ready one-hot)
//             req_a/req_b            - packed operands, slice [i*WIDTH +: WIDTH]
//             rsp_valid/rsp_ready    - shared response handshake
//             rsp_y/rsp_id           - XOR result and owning requester index
//             busy                   - high whenever not in IDLE
//             ops_done               - completed-response counter (16 bit),
//                                      present only with XOR_SCHED_STATS_EN
//  Options  : `define XOR_SCHED_STATS_EN to add the ops_done counter/port.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_y,
    output logic [IDW-1:0]          rsp_id,
`ifdef XOR_SCHED_STATS_EN
    output logic [15:0]             ops_done,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [IDW-1:0]     op_id_q;
    logic [WIDTH-1:0]   rsp_y_q;
    logic [IDW-1:0]     rsp_id_q;
    logic               rsp_valid_q;
`ifdef XOR_SCHED_STATS_EN
    logic [15:0]        ops_done_q;
`endif

    // Round-robin search: start one past the last granted index and take
    // the first valid requester, wrapping modulo NREQ. Works for any NREQ,
    // not just powers of two.
    logic               grant_any_d;
    logic [IDW-1:0]     grant_idx_d;
    logic [IDW-1:0]     cand_d;

    always_comb begin
        grant_any_d = 1'b0;
        grant_idx_d = '0;
        cand_d      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_d = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_any_d && req_valid[cand_d]) begin
                grant_any_d = 1'b1;
                grant_idx_d = cand_d;
            end
        end
    end

    // State resets asynchronously to IDLE, so rst is folded in here to keep
    // the grant silent for the whole time reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == S_IDLE) && grant_any_d) begin
            req_ready = NREQ'(1) << grant_idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef XOR_SCHED_STATS_EN
            ops_done_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        op_a_q   <= req_a[grant_idx_d*WIDTH +: WIDTH];
                        op_b_q   <= req_b[grant_idx_d*WIDTH +: WIDTH];
                        op_id_q  <= grant_idx_d;
                        rr_ptr_q <= grant_idx_d;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_y_q     <= op_a_q ^ op_b_q;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
`ifdef XOR_SCHED_STATS_EN
                        ops_done_q  <= ops_done_q + 16'd1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
`ifdef XOR_SCHED_STATS_EN
    assign ops_done  = ops_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_sched
//  Purpose  : Self-checking bench for xor_sched (NREQ=4, WIDTH=8). A
//             transaction-level reference model (last-granted index, pending
//             request mask, stored operands) predicts grants and results.
//             Build with XOR_SCHED_STATS_EN to also exercise ops_done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [WIDTH-1:0]      rsp_y;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
`ifdef XOR_SCHED_STATS_EN
    logic [15:0]           ops_done;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int               m_last = 3;
    logic [7:0]       ma [4];
    logic [7:0]       mb [4];
    logic [3:0]       one4 = 4'b0001;

    logic [7:0] ta [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] tb [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] ty [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};

    xor_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
`ifdef XOR_SCHED_STATS_EN
        .ops_done  (ops_done),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin rule: first requesting index after the last grant, wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        ma[i] = a;
        mb[i] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_y, rsp_id, busy} !== {1'b0, 8'h00, 2'd0, 1'b0}) begin
            bad++; $display("FAIL reset_outputs: got valid=%b y=%h id=%0d busy=%b expected 0/00/0/0",
                            rsp_valid, rsp_y, rsp_id, busy);
        end
        req_valid = '0;
        rst = 1'b0;
        m_last = 3;
    endtask

    task automatic test_single();
        set_ops(0, 8'h0F, 8'h3C);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        m_last = 0;
        total++;
        if ({rsp_valid, busy} !== 2'b01) begin
            bad++; $display("FAIL single_exec: got valid=%b busy=%b expected 0/1", rsp_valid, busy);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_y, rsp_id} !== {1'b1, 8'h33, 2'd0}) begin
            bad++; $display("FAIL single_resp: got valid=%b y=%h id=%0d expected 1/33/0",
                            rsp_valid, rsp_y, rsp_id);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL single_done: got valid=%b busy=%b expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_truth();
        for (int i = 0; i < 4; i++) begin
            set_ops(2, ta[i], tb[i]);
            req_valid = 4'b0100;
            rsp_ready = 1'b1;
            #1;
            total++;
            if (req_ready !== 4'b0100) begin
                bad++; $display("FAIL truth_grant[%0d]: got %b expected 0100", i, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            m_last = 2;
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_y, rsp_id} !== {1'b1, ty[i], 2'd2}) begin
                bad++; $display("FAIL truth_resp[%0d]: got valid=%b y=%h id=%0d expected 1/%h/2",
                                i, rsp_valid, rsp_y, rsp_id, ty[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int e;
        int prev;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
        for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            #1;
            e = rr_pick(4'b1111, m_last);
            total++;
            if (req_ready !== (one4 << e)) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, req_ready, one4 << e);
            end
            if (t > 0) begin
                total++;
                if (cyc - prev != 3) begin
                    bad++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", t, cyc - prev);
                end
            end
            prev = cyc;
            @(negedge clk);
            m_last = e;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL rr_exec_ready[%0d]: got %b expected 0000", t, req_ready);
            end
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_y, rsp_id, req_ready} !== {1'b1, ma[e] ^ mb[e], 2'(e), 4'b0000}) begin
                bad++; $display("FAIL rr_resp[%0d]: got valid=%b y=%h id=%0d ready=%b expected 1/%h/%0d/0000",
                                t, rsp_valid, rsp_y, rsp_id, req_ready, ma[e] ^ mb[e], e);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [7:0] ey;
        set_ops(3, 8'($urandom), 8'($urandom));
        ey = ma[3] ^ mb[3];
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL bp_grant: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        m_last = 3;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            total++;
            if ({rsp_valid, rsp_y, rsp_id, req_ready} !== {1'b1, ey, 2'd3, 4'b0000}) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b y=%h id=%0d ready=%b expected 1/%h/3/0000",
                                j, rsp_valid, rsp_y, rsp_id, req_ready, ey);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_before_edge: got valid=%b expected 1", rsp_valid);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_midop();
        int e;
        set_ops(2, 8'($urandom), 8'($urandom));
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL rmid_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        m_last = 2;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_resp: got valid=%b expected 1", rsp_valid);
        end
        #2;
        rst = 1'b1;
        set_ops(1, 8'($urandom), 8'($urandom));
        set_ops(3, 8'($urandom), 8'($urandom));
        req_valid = 4'b1010;
        #1;
        total++;
        if ({rsp_valid, rsp_y, busy, req_ready} !== {1'b0, 8'h00, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL rmid_abort: got valid=%b y=%h busy=%b ready=%b expected 0/00/0/0000",
                            rsp_valid, rsp_y, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
        rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            #1;
            e = rr_pick(req_valid, m_last);
            total++;
            if (req_ready !== (one4 << e)) begin
                bad++; $display("FAIL rmid_regrant[%0d]: got %b expected %b", t, req_ready, one4 << e);
            end
            @(negedge clk);
            req_valid[e] = 1'b0;
            m_last = e;
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_y, rsp_id} !== {1'b1, ma[e] ^ mb[e], 2'(e)}) begin
                bad++; $display("FAIL rmid_result[%0d]: got valid=%b y=%h id=%0d expected 1/%h/%0d",
                                t, rsp_valid, rsp_y, rsp_id, ma[e] ^ mb[e], e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [3:0] pend;
        int e;
        int d;
        int r;
        pend = '0;
        for (int t = 0; (t < 40) || (pend != 0); t++) begin
            if (t < 40) begin
                for (int i = 0; i < 4; i++) begin
                    if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                        pend[i] = 1'b1;
                        set_ops(i, 8'($urandom), 8'($urandom));
                    end
                end
                if (pend == 0) begin
                    r = int'($urandom_range(0, 3));
                    pend[r] = 1'b1;
                    set_ops(r, 8'($urandom), 8'($urandom));
                end
            end
            req_valid = pend;
            rsp_ready = 1'b0;
            #1;
            e = rr_pick(pend, m_last);
            total++;
            if (req_ready !== (one4 << e)) begin
                bad++; $display("FAIL rand_grant[%0d]: got %b expected %b (pending %b)",
                                t, req_ready, one4 << e, pend);
            end
            @(negedge clk);
            pend[e] = 1'b0;
            req_valid = pend;
            m_last = e;
            total++;
            if ({rsp_valid, busy} !== 2'b01) begin
                bad++; $display("FAIL rand_exec[%0d]: got valid=%b busy=%b expected 0/1", t, rsp_valid, busy);
            end
            @(negedge clk);
            d = int'($urandom_range(0, 3));
            for (int j = 0; j <= d; j++) begin
                total++;
                if ({rsp_valid, rsp_y, rsp_id, req_ready} !== {1'b1, ma[e] ^ mb[e], 2'(e), 4'b0000}) begin
                    bad++; $display("FAIL rand_resp[%0d.%0d]: got valid=%b y=%h id=%0d ready=%b expected 1/%h/%0d/0000",
                                    t, j, rsp_valid, rsp_y, rsp_id, req_ready, ma[e] ^ mb[e], e);
                end
                if (j < d) @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++; $display("FAIL rand_drop[%0d]: got valid=%b expected 0", t, rsp_valid);
            end
        end
        req_valid = '0;
    endtask

`ifdef XOR_SCHED_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
        total++;
        if (ops_done !== 16'd0) begin
            bad++; $display("FAIL stats_reset: got %h expected 0000", ops_done);
        end
        rsp_ready = 1'b1;
        set_ops(0, 8'h12, 8'h34);
        for (int t = 0; t < 4; t++) begin
            if (t == 3) begin
                force dut.ops_done_q = 16'hFFFF;
                #1;
                release dut.ops_done_q;
            end
            req_valid = 4'b0001;
            @(negedge clk);
            req_valid = '0;
            m_last = 0;
            repeat (2) @(negedge clk);
            if (t == 2) begin
                total++;
                if (ops_done !== 16'd3) begin
                    bad++; $display("FAIL stats_count: got %h expected 0003", ops_done);
                end
            end
        end
        total++;
        if (ops_done !== 16'd0) begin
            bad++; $display("FAIL stats_wrap: got %h expected 0000", ops_done);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_truth();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
`ifdef XOR_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
